// File: rtl/mor1kx_bp_pht_ctrl_if.sv
// Lookup, update and RAM-side signals of the PHT controller.
interface mor1kx_bp_pht_ctrl_if #(
  parameter int unsigned IW = 10
);
  logic          lookup_req_i;
  logic [IW-1:0] lookup_idx_i;
  logic          lookup_valid_o;
  logic [1:0]    lookup_cnt_o;

  logic          upd_req_i;
  logic [IW-1:0] upd_idx_i;
  logic [1:0]    upd_cnt_i;
  logic          upd_taken_i;
  logic          upd_full_o;
  logic          upd_drop_o;

  logic          ram_en_o;
  logic          ram_we_o;
  logic [IW-1:0] ram_addr_o;
  logic [1:0]    ram_wdata_o;
  logic [1:0]    ram_rdata_i;

  // Controller side
  modport slave (
    input  lookup_req_i, lookup_idx_i, upd_req_i, upd_idx_i, upd_cnt_i,
           upd_taken_i, ram_rdata_i,
    output lookup_valid_o, lookup_cnt_o, upd_full_o, upd_drop_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  // Pipeline / RAM side
  modport master (
    output lookup_req_i, lookup_idx_i, upd_req_i, upd_idx_i, upd_cnt_i,
           upd_taken_i, ram_rdata_i,
    input  lookup_valid_o, lookup_cnt_o, upd_full_o, upd_drop_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mor1kx_bp_pht_ctrl.sv
// PHT RAM controller: table init, prediction lookups and queued counter
// updates with forwarding from the queue to lookups.
module mor1kx_bp_pht_ctrl #(
  parameter int unsigned OPTION_PHT_INDEX_WIDTH = 10,
  parameter int unsigned OPTION_UPD_QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  output logic busy_o,
  mor1kx_bp_pht_ctrl_if.slave bus
);

  localparam int unsigned IW    = OPTION_PHT_INDEX_WIDTH;
  localparam int unsigned DEPTH = OPTION_UPD_QUEUE_DEPTH;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_ptr_q, init_ptr_d;

  logic [IW-1:0] q_idx [DEPTH];
  logic [1:0]    q_val [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          lookup_valid_q;
  logic          fwd_hit_q;
  logic [1:0]    fwd_val_q;
  logic [1:0]    cnt_hold_q;
  logic          full_q;
  logic          busy_q;

  logic          q_full, q_empty;
  logic          grant, enq, deq, drop;
  logic          ram_en, ram_we;
  logic [IW-1:0] ram_addr;
  logic [1:0]    ram_wdata;
  logic [1:0]    new_val;
  logic          fwd_hit;
  logic [1:0]    fwd_val;
  logic [PW-1:0] fwd_slot;

  assign q_full  = (count_q == CW'(DEPTH));
  assign q_empty = (count_q == '0);

  // Saturating counter step applied at enqueue time
  always_comb begin
    new_val = bus.upd_cnt_i;
    if (bus.upd_taken_i) begin
      if (bus.upd_cnt_i != 2'b11) new_val = bus.upd_cnt_i + 2'b01;
    end else begin
      if (bus.upd_cnt_i != 2'b00) new_val = bus.upd_cnt_i - 2'b01;
    end
  end

  // Youngest queued entry matching the lookup index
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_val  = 2'b00;
    fwd_slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_slot = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (q_idx[fwd_slot] == bus.lookup_idx_i)) begin
        fwd_hit = 1'b1;
        fwd_val = q_val[fwd_slot];
      end
    end
  end

  // Next state, RAM port arbitration and queue control
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = 2'b00;
    grant      = 1'b0;
    enq        = 1'b0;
    deq        = 1'b0;
    drop       = 1'b0;

    if (state_q == ST_INIT) begin
      ram_en     = 1'b1;
      ram_we     = 1'b1;
      ram_addr   = init_ptr_q;
      ram_wdata  = 2'b01;
      init_ptr_d = init_ptr_q + IW'(1);
      drop       = bus.upd_req_i;
      if (init_ptr_q == {IW{1'b1}}) state_d = ST_RUN;
    end else if (flush_i) begin
      drop = bus.upd_req_i;
    end else begin
      enq = bus.upd_req_i;
      if (q_full) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = q_idx[rd_ptr_q];
        ram_wdata = q_val[rd_ptr_q];
        deq       = 1'b1;
      end else if (bus.lookup_req_i) begin
        ram_en   = 1'b1;
        ram_addr = bus.lookup_idx_i;
        grant    = 1'b1;
      end else if (!q_empty) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = q_idx[rd_ptr_q];
        ram_wdata = q_val[rd_ptr_q];
        deq       = 1'b1;
      end
    end

    if (flush_i) begin
      state_d    = ST_INIT;
      init_ptr_d = '0;
    end

    // No RAM traffic and no queue activity while reset is asserted
    if (!rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
      grant  = 1'b0;
      enq    = 1'b0;
      deq    = 1'b0;
      drop   = 1'b0;
    end

    count_d = flush_i ? '0 : (count_q + CW'(enq) - CW'(deq));
  end

  // State, pointers, lookup result capture and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_INIT;
      init_ptr_q     <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      lookup_valid_q <= 1'b0;
      fwd_hit_q      <= 1'b0;
      fwd_val_q      <= 2'b00;
      cnt_hold_q     <= 2'b00;
      full_q         <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q        <= count_d;
      lookup_valid_q <= grant;
      if (grant) begin
        fwd_hit_q <= fwd_hit;
        fwd_val_q <= fwd_val;
      end
      cnt_hold_q <= bus.lookup_cnt_o;
      full_q     <= (count_d == CW'(DEPTH));
      busy_q     <= (state_d == ST_INIT);
    end
  end

  // Queue storage; contents only meaningful below count_q
  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx[wr_ptr_q] <= bus.upd_idx_i;
      q_val[wr_ptr_q] <= new_val;
    end
  end

  assign bus.lookup_valid_o = lookup_valid_q;
  assign bus.lookup_cnt_o   = lookup_valid_q ? (fwd_hit_q ? fwd_val_q : bus.ram_rdata_i)
                                             : cnt_hold_q;
  assign bus.upd_full_o     = full_q;
  assign bus.upd_drop_o     = drop;
  assign bus.ram_en_o       = ram_en;
  assign bus.ram_we_o       = ram_we;
  assign bus.ram_addr_o     = ram_addr;
  assign bus.ram_wdata_o    = ram_wdata;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_mor1kx_bp_pht_ctrl.sv
// Self-checking bench for mor1kx_bp_pht_ctrl with a queue-based reference model.
module tb_mor1kx_bp_pht_ctrl;

  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int          N     = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic busy;

  mor1kx_bp_pht_ctrl_if #(.IW(IW)) bus ();

  mor1kx_bp_pht_ctrl #(
    .OPTION_PHT_INDEX_WIDTH(IW),
    .OPTION_UPD_QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .busy_o (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
      else              bus.ram_rdata_i     <= mem[bus.ram_addr_o];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: table contents, pending updates in FIFO order
  typedef struct {
    int idx;
    int val;
  } ent_t;

  ent_t q[$];
  int   shadow [N];
  bit   m_known = 1'b0;
  bit   m_init  = 1'b1;
  int   m_ptr   = 0;
  bit   e_valid = 1'b0;
  int   e_cnt   = 0;

  function automatic int sat_step(input int c, input bit t);
    int v;
    v = t ? c + 1 : c - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  // One clock cycle: drive, check against model, advance model
  task automatic step(input bit r, input bit f, input bit lr, input int li,
                      input bit ur, input int ui, input int uc, input bit ut);
    bit en, we, grant, deq, drop, enq;
    int addr, wd;
    @(negedge clk);
    rst              = r;
    flush            = f;
    bus.lookup_req_i = lr;
    bus.lookup_idx_i = IW'(li);
    bus.upd_req_i    = ur;
    bus.upd_idx_i    = IW'(ui);
    bus.upd_cnt_i    = 2'(uc);
    bus.upd_taken_i  = ut;
    #1;
    en = 0; we = 0; grant = 0; deq = 0; drop = 0; addr = 0; wd = 0;
    if (r) begin
      if (m_init) begin
        en = 1; we = 1; addr = m_ptr; wd = 1; drop = ur;
      end else if (f) begin
        drop = ur;
      end else if (q.size() == DEPTH) begin
        en = 1; we = 1; addr = q[0].idx; wd = q[0].val; deq = 1;
      end else if (lr) begin
        en = 1; addr = li; grant = 1;
      end else if (q.size() > 0) begin
        en = 1; we = 1; addr = q[0].idx; wd = q[0].val; deq = 1;
      end
    end
    chk("ram_en", int'(bus.ram_en_o), int'(en));
    if (en) begin
      chk("ram_we", int'(bus.ram_we_o), int'(we));
      chk("ram_addr", int'(bus.ram_addr_o), addr);
      if (we) chk("ram_wdata", int'(bus.ram_wdata_o), wd);
    end
    chk("upd_drop", int'(bus.upd_drop_o), int'(drop));
    if (m_known) begin
      chk("lookup_valid", int'(bus.lookup_valid_o), int'(e_valid));
      chk("lookup_cnt", int'(bus.lookup_cnt_o), e_cnt);
      chk("upd_full", int'(bus.upd_full_o), int'(q.size() == DEPTH));
      chk("busy", int'(busy), int'(m_init));
    end
    if (!r) begin
      m_known = 1; m_init = 1; m_ptr = 0; q.delete(); e_valid = 0; e_cnt = 0;
    end else begin
      if (grant) begin
        e_cnt = shadow[li];
        foreach (q[k]) if (q[k].idx == li) e_cnt = q[k].val;
      end
      e_valid = grant;
      if (we) shadow[addr] = wd;
      if (deq) void'(q.pop_front());
      enq = !m_init && !f && ur;
      if (m_init) begin
        m_ptr++;
        if (m_ptr == N) m_init = 0;
      end
      if (f) begin
        m_init = 1; m_ptr = 0; q.delete();
      end
      if (enq) q.push_back('{ui, sat_step(uc, ut)});
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int cnt;
    bit taken;
    int exp;
  } sat_vec_t;

  sat_vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 1'b0, 0};
    tbl[1] = '{1, 1'b0, 0};
    tbl[2] = '{2, 1'b0, 1};
    tbl[3] = '{3, 1'b0, 2};
    tbl[4] = '{0, 1'b1, 1};
    tbl[5] = '{1, 1'b1, 2};
    tbl[6] = '{2, 1'b1, 3};
    tbl[7] = '{3, 1'b1, 3};

    bus.lookup_req_i = 0; bus.lookup_idx_i = '0; bus.upd_req_i = 0;
    bus.upd_idx_i = '0; bus.upd_cnt_i = '0; bus.upd_taken_i = 0;

    // Reset values
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 1, 3, 1, 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_valid", int'(bus.lookup_valid_o), 0);
    chk("rst_cnt", int'(bus.lookup_cnt_o), 0);
    chk("rst_full", int'(bus.upd_full_o), 0);
    chk("rst_drop", int'(bus.upd_drop_o), 0);

    // Reset halfway through init restarts the pointer
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Full init with lookups and updates arriving meanwhile
    for (int i = 0; i < N; i++) begin
      step(1, 0, 1, i, 1, i, 2, 1);
      chk("init_busy", int'(busy), 1);
      chk("init_addr", int'(bus.ram_addr_o), i);
      chk("init_wdata", int'(bus.ram_wdata_o), 1);
      chk("init_drop", int'(bus.upd_drop_o), 1);
      if (i > 0) chk("init_valid", int'(bus.lookup_valid_o), 0);
    end
    idle();
    chk("init_done_busy", int'(busy), 0);
    chk("init_done_valid", int'(bus.lookup_valid_o), 0);

    // Lookup latency: idx 5 holds 2'b10
    step(1, 0, 0, 0, 1, 5, 1, 1);
    idle();
    step(1, 0, 1, 5, 0, 0, 0, 0);
    chk("lat_read", int'(bus.ram_we_o), 0);
    idle();
    chk("lat_valid", int'(bus.lookup_valid_o), 1);
    chk("lat_cnt", int'(bus.lookup_cnt_o), 2);
    idle();
    chk("lat_hold_valid", int'(bus.lookup_valid_o), 0);
    chk("lat_hold_cnt", int'(bus.lookup_cnt_o), 2);

    // Forwarding: two updates to idx 5 while lookups own the port
    step(1, 0, 1, 0, 1, 5, 2, 1);
    step(1, 0, 1, 1, 1, 5, 3, 0);
    step(1, 0, 1, 5, 0, 0, 0, 0);
    chk("fwd_fullwr_addr", int'(bus.ram_addr_o), 5);
    chk("fwd_fullwr_data", int'(bus.ram_wdata_o), 3);
    step(1, 0, 1, 5, 0, 0, 0, 0);
    chk("fwd_ungranted", int'(bus.lookup_valid_o), 0);
    idle();
    chk("fwd_valid", int'(bus.lookup_valid_o), 1);
    chk("fwd_cnt", int'(bus.lookup_cnt_o), 2);
    idle();

    // Full queue: update in the full cycle is accepted
    step(1, 0, 1, 0, 1, 9, 0, 1);
    step(1, 0, 1, 0, 1, 10, 0, 1);
    step(1, 0, 1, 0, 1, 11, 2, 0);
    chk("full_flag", int'(bus.upd_full_o), 1);
    chk("full_wr_addr", int'(bus.ram_addr_o), 9);
    chk("full_no_drop", int'(bus.upd_drop_o), 0);
    idle();
    chk("full_no_grant", int'(bus.lookup_valid_o), 0);
    for (int i = 0; i < 3; i++) idle();

    // Saturating counter vectors
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 1, i + 2, tbl[i].cnt, tbl[i].taken);
      idle();
      chk("sat_we", int'(bus.ram_we_o), 1);
      chk("sat_wdata", int'(bus.ram_wdata_o), tbl[i].exp);
    end

    // Flush with two queued entries
    step(1, 0, 1, 0, 1, 12, 1, 1);
    step(1, 0, 1, 0, 1, 13, 1, 1);
    step(1, 1, 1, 0, 1, 14, 1, 1);
    chk("flush_drop", int'(bus.upd_drop_o), 1);
    chk("flush_no_write", int'(bus.ram_en_o), 0);
    for (int i = 0; i < N; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("reinit_addr", int'(bus.ram_addr_o), i);
      chk("reinit_wdata", int'(bus.ram_wdata_o), 1);
    end
    idle();
    chk("reinit_busy", int'(busy), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
